// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ALU ops,
// ALUSrcB selects, and the opcode / funct constants it decodes.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REX, S_RWB, S_BRANCH, S_IEX, S_IWB
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

endpackage

// File: rtl/multi_cycle_controller_alu_decode.sv
// Maps op/func to the ALU operation and immediate extension mode; legal
// flags any encoding the controller knows how to execute.
module mips_alu_decode
  import multi_cycle_controller_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [3:0] alu_op,
  output logic       sz_en,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    sz_en  = 1'b0;
    legal  = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:         alu_op = ALU_AND;
          F_OR:          alu_op = ALU_OR;
          F_XOR:         alu_op = ALU_XOR;
          F_NOR:         alu_op = ALU_NOR;
          F_SLT:         alu_op = ALU_SLT;
          F_SLTU:        alu_op = ALU_SLTU;
          default:       legal  = 1'b0;
        endcase
      end
      OP_ADDI:  sz_en  = 1'b1;
      OP_ADDIU: alu_op = ALU_ADD;
      OP_SLTI:  begin alu_op = ALU_SLT; sz_en = 1'b1; end
      OP_SLTIU: alu_op = ALU_SLTU;
      OP_ANDI:  alu_op = ALU_AND;
      OP_ORI:   alu_op = ALU_OR;
      OP_XORI:  alu_op = ALU_XOR;
      OP_LUI:   alu_op = ALU_LUI;
      OP_LW, OP_SW, OP_BEQ, OP_BNE: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM: Moore outputs per state (PCWrite in BRANCH
// is Mealy on AluZero), memory waits via mem_ready, write enables gated by reset.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       AluZero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCSrc,
  output logic       SZEn,
  output logic [1:0] ALUSrcB,
  output logic [3:0] AluOP,
  output logic       instr_done,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [3:0] dec_alu_op;
  logic       dec_sz_en, dec_legal;

  mips_alu_decode u_dec (
    .op     (op),
    .func   (func),
    .alu_op (dec_alu_op),
    .sz_en  (dec_sz_en),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    PCSrc      = 1'b0;
    SZEn       = 1'b0;
    ALUSrcB    = SRCB_RD2;
    AluOP      = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        SZEn    = 1'b1;
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_REX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          default: begin
            // Everything left that decodes as legal is an I-type ALU op.
            if (dec_legal) state_d = S_IEX;
            else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        SZEn    = 1'b1;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        if (dec_legal) begin
          AluOP   = dec_alu_op;
          state_d = S_RWB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        AluOP      = dec_alu_op;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        AluOP      = ALU_SUB;
        PCSrc      = 1'b1;
        instr_done = 1'b1;
        PCWrite    = ((op == OP_BEQ) & AluZero) | ((op == OP_BNE) & ~AluZero);
        state_d    = S_FETCH;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        AluOP   = dec_alu_op;
        SZEn    = dec_sz_en;
        state_d = S_IWB;
      end
      S_IWB: begin
        ALUSrcB    = SRCB_IMM;
        AluOP      = dec_alu_op;
        SZEn       = dec_sz_en;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset must never let a write or completion strobe escape.
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: instruction table, per-class expected cycle sequences
// with memory waits, randomized instruction streams and reset corner cases.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       reset, AluZero, mem_ready;
  logic [5:0] op, func;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCSrc, SZEn, instr_done, illegal;
  logic [1:0] ALUSrcB;
  logic [3:0] AluOP;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .AluZero(AluZero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .PCSrc(PCSrc), .SZEn(SZEn), .ALUSrcB(ALUSrcB),
    .AluOP(AluOP), .instr_done(instr_done), .illegal(illegal)
  );

  typedef enum int {K_LW, K_SW, K_R, K_RILL, K_BR, K_I, K_ILL} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    kind_e      kind;
    logic [3:0] aop;
    logic       sz;
  } vec_t;

  typedef struct {
    logic        rdy;
    logic        z;
    logic [17:0] exp;
  } cyc_t;

  localparam logic [17:0] ALL_MASK = 18'h3FFFF;
  localparam logic [17:0] EN_MASK  = 18'h2C803;

  vec_t tbl[26];
  cyc_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Bit order: PCWrite IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
  // PCSrc SZEn ALUSrcB[1:0] AluOP[3:0] instr_done illegal
  function automatic logic [17:0] mk(logic pcw, logic iord, logic mw, logic irw,
      logic rd, logic m2r, logic rw, logic sa, logic pcs, logic sz,
      logic [1:0] sb, logic [3:0] aop, logic done, logic ill);
    return {pcw, iord, mw, irw, rd, m2r, rw, sa, pcs, sz, sb, aop, done, ill};
  endfunction

  function automatic logic [17:0] act_vec();
    return {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
            ALUSrcA, PCSrc, SZEn, ALUSrcB, AluOP, instr_done, illegal};
  endfunction

  task automatic step(input logic rdy, input logic z, input logic rst,
                      input logic [17:0] exp, input logic [17:0] mask,
                      input string name);
    logic [17:0] a;
    mem_ready = rdy;
    AluZero   = z;
    reset     = rst;
    #1;
    a = act_vec();
    n_chk++;
    if ((a & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s t=%0t op=%b func=%b outputs=%h expected=%h mask=%h",
               name, $time, op, func, a, exp, mask);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic z, input logic [17:0] e);
    cyc_t c;
    c.rdy = rdy; c.z = z; c.exp = e;
    q.push_back(c);
  endtask

  // Expected per-cycle outputs for one instruction; fw/mw are mem_ready=0
  // cycles in fetch and in the data access.
  task automatic build(input vec_t v, input int fw, input int mw, input logic bz);
    logic [17:0] fe;
    fe = mk(0,0,0,0,0,0,0,0,0,0,2'b01,4'd0,0,0);
    for (int i = 0; i < fw; i++) push(1'b0, rb(), fe);
    push(1'b1, rb(), fe | mk(1,0,0,1,0,0,0,0,0,0,2'b00,4'd0,0,0));
    push(rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,2'b11,4'd0,0, v.kind == K_ILL));
    case (v.kind)
      K_LW: begin
        push(rb(), rb(), mk(0,0,0,0,0,0,0,1,0,1,2'b10,4'd0,0,0));
        for (int i = 0; i < mw; i++) push(1'b0, rb(), mk(0,1,0,0,0,0,0,0,0,0,2'b00,4'd0,0,0));
        push(1'b1, rb(), mk(0,1,0,0,0,0,0,0,0,0,2'b00,4'd0,0,0));
        push(rb(), rb(), mk(0,0,0,0,0,1,1,0,0,0,2'b00,4'd0,1,0));
      end
      K_SW: begin
        push(rb(), rb(), mk(0,0,0,0,0,0,0,1,0,1,2'b10,4'd0,0,0));
        for (int i = 0; i < mw; i++) push(1'b0, rb(), mk(0,1,1,0,0,0,0,0,0,0,2'b00,4'd0,0,0));
        push(1'b1, rb(), mk(0,1,1,0,0,0,0,0,0,0,2'b00,4'd0,1,0));
      end
      K_R: begin
        push(rb(), rb(), mk(0,0,0,0,0,0,0,1,0,0,2'b00,v.aop,0,0));
        push(rb(), rb(), mk(0,0,0,0,1,0,1,0,0,0,2'b00,v.aop,1,0));
      end
      K_RILL: push(rb(), rb(), mk(0,0,0,0,0,0,0,1,0,0,2'b00,4'd0,0,1));
      K_BR: begin
        logic tk;
        tk = (v.op == 6'b000100) ? bz : ~bz;
        push(rb(), bz, mk(tk,0,0,0,0,0,0,1,1,0,2'b00,4'd1,1,0));
      end
      K_I: begin
        push(rb(), rb(), mk(0,0,0,0,0,0,0,1,0,v.sz,2'b10,v.aop,0,0));
        push(rb(), rb(), mk(0,0,0,0,0,0,1,0,0,v.sz,2'b10,v.aop,1,0));
      end
      default: ;
    endcase
  endtask

  task automatic run_instr(input vec_t v, input int fw, input int mw,
                           input logic bz, input string name);
    cyc_t c;
    op   = v.op;
    func = (v.kind == K_R || v.kind == K_RILL) ? v.func : 6'($urandom);
    q.delete();
    build(v, fw, mw, bz);
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c.rdy, c.z, 1'b0, c.exp, ALL_MASK, name);
    end
  endtask

  function automatic vec_t ent(logic [5:0] o, logic [5:0] f, kind_e k,
                               logic [3:0] a, logic s);
    vec_t v;
    v.op = o; v.func = f; v.kind = k; v.aop = a; v.sz = s;
    return v;
  endfunction

  initial begin
    logic [17:0] fe;
    fe = mk(0,0,0,0,0,0,0,0,0,0,2'b01,4'd0,0,0);

    tbl[0]  = ent(6'b100011, 6'd0,      K_LW,   4'd0, 0);
    tbl[1]  = ent(6'b101011, 6'd0,      K_SW,   4'd0, 0);
    tbl[2]  = ent(6'b000100, 6'd0,      K_BR,   4'd1, 0);
    tbl[3]  = ent(6'b000101, 6'd0,      K_BR,   4'd1, 0);
    tbl[4]  = ent(6'b000000, 6'b100000, K_R,    4'd0, 0);
    tbl[5]  = ent(6'b000000, 6'b100001, K_R,    4'd0, 0);
    tbl[6]  = ent(6'b000000, 6'b100010, K_R,    4'd1, 0);
    tbl[7]  = ent(6'b000000, 6'b100011, K_R,    4'd1, 0);
    tbl[8]  = ent(6'b000000, 6'b100100, K_R,    4'd4, 0);
    tbl[9]  = ent(6'b000000, 6'b100101, K_R,    4'd5, 0);
    tbl[10] = ent(6'b000000, 6'b100110, K_R,    4'd7, 0);
    tbl[11] = ent(6'b000000, 6'b100111, K_R,    4'd6, 0);
    tbl[12] = ent(6'b000000, 6'b101010, K_R,    4'd2, 0);
    tbl[13] = ent(6'b000000, 6'b101011, K_R,    4'd3, 0);
    tbl[14] = ent(6'b000000, 6'b000111, K_RILL, 4'd0, 0);
    tbl[15] = ent(6'b001000, 6'd0,      K_I,    4'd0, 1);
    tbl[16] = ent(6'b001001, 6'd0,      K_I,    4'd0, 0);
    tbl[17] = ent(6'b001010, 6'd0,      K_I,    4'd2, 1);
    tbl[18] = ent(6'b001011, 6'd0,      K_I,    4'd3, 0);
    tbl[19] = ent(6'b001100, 6'd0,      K_I,    4'd4, 0);
    tbl[20] = ent(6'b001101, 6'd0,      K_I,    4'd5, 0);
    tbl[21] = ent(6'b001110, 6'd0,      K_I,    4'd7, 0);
    tbl[22] = ent(6'b001111, 6'd0,      K_I,    4'd8, 0);
    tbl[23] = ent(6'b111111, 6'd0,      K_ILL,  4'd0, 0);
    tbl[24] = ent(6'b000010, 6'd0,      K_ILL,  4'd0, 0);
    tbl[25] = ent(6'b000000, 6'b111111, K_RILL, 4'd0, 0);

    op = 6'b100011; func = 6'd0; AluZero = 1'b0; mem_ready = 1'b1; reset = 1'b1;
    #1;
    step(1'b1, 1'b0, 1'b1, 18'd0, EN_MASK, "reset_enables");
    step(1'b1, 1'b0, 1'b1, 18'd0, EN_MASK, "reset_hold");

    for (int i = 0; i < 26; i++) run_instr(tbl[i], 0, 0, 1'b1, "table");

    run_instr(tbl[1], 0, 2, 1'b0, "sw_wait2");
    run_instr(tbl[2], 0, 0, 1'b1, "beq_taken");
    run_instr(tbl[3], 0, 0, 1'b1, "bne_not_taken");
    run_instr(tbl[0], 3, 4, 1'b0, "lw_waits");

    // Reset while an lw waits in MEMRD: no write-back may follow.
    op = 6'b100011;
    step(1'b1, 1'b0, 1'b0, fe | mk(1,0,0,1,0,0,0,0,0,0,2'b00,4'd0,0,0), ALL_MASK, "rst_fetch");
    step(1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,1,2'b11,4'd0,0,0), ALL_MASK, "rst_decode");
    step(1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,1,0,1,2'b10,4'd0,0,0), ALL_MASK, "rst_memadr");
    step(1'b0, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,2'b00,4'd0,0,0), ALL_MASK, "rst_memrd");
    step(1'b1, 1'b0, 1'b1, 18'd0, EN_MASK, "rst_in_memrd");
    step(1'b0, 1'b0, 1'b0, fe, ALL_MASK, "after_rst_fetch");
    run_instr(tbl[0], 0, 0, 1'b0, "lw_after_rst");

    // Reset during a held sw write wait.
    op = 6'b101011;
    step(1'b1, 1'b0, 1'b0, fe | mk(1,0,0,1,0,0,0,0,0,0,2'b00,4'd0,0,0), ALL_MASK, "rsw_fetch");
    step(1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,1,2'b11,4'd0,0,0), ALL_MASK, "rsw_decode");
    step(1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,1,0,1,2'b10,4'd0,0,0), ALL_MASK, "rsw_memadr");
    step(1'b0, 1'b0, 1'b0, mk(0,1,1,0,0,0,0,0,0,0,2'b00,4'd0,0,0), ALL_MASK, "rsw_memwr");
    step(1'b1, 1'b0, 1'b1, 18'd0, EN_MASK, "rst_in_memwr");
    step(1'b1, 1'b0, 1'b0, fe | mk(1,0,0,1,0,0,0,0,0,0,2'b00,4'd0,0,0), ALL_MASK, "after_rsw_fetch");
    step(1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,1,2'b11,4'd0,0,0), ALL_MASK, "after_rsw_decode");
    step(1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,1,0,1,2'b10,4'd0,0,0), ALL_MASK, "after_rsw_memadr");
    step(1'b1, 1'b0, 1'b0, mk(0,1,1,0,0,0,0,0,0,0,2'b00,4'd0,1,0), ALL_MASK, "after_rsw_memwr");

    for (int n = 0; n < 300; n++) begin
      int idx;
      idx = $urandom_range(0, 25);
      run_instr(tbl[idx], $urandom_range(0, 3), $urandom_range(0, 3), rb(), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
